lib_switch_arb_xbar: RTL

//   NxM packet_t crossbar with per-output round-robin arbitration and one registered output slot per port.

---
 rtl/lib_switch_pkg.sv | 20 ++
 rtl/lib_switch_rr_arbiter.sv | 38 +++
 rtl/lib_switch_arb_xbar.sv | 101 ++++++++++
 3 files changed

// File: rtl/lib_switch_pkg.sv
// Shared constants, packet type and request helper for the lib_switch crossbar.
package lib_switch_pkg;

  localparam int LIB_SWITCH_N         = 5;
  localparam int LIB_SWITCH_M         = 5;
  localparam int LIB_SWITCH_CNT_W     = 16;
  localparam int LIB_SWITCH_PKT_W     = 32;
  localparam int LIB_SWITCH_MAX_PORTS = 32;

  // Mirrors the codebase-wide packet_t so this library compiles standalone.
  typedef logic [LIB_SWITCH_PKT_W-1:0] packet_t;

  // Keeps only the lowest set bit so a multi-hot destination resolves deterministically.
  function automatic logic [LIB_SWITCH_MAX_PORTS-1:0] lowest_onehot(
    input logic [LIB_SWITCH_MAX_PORTS-1:0] req
  );
    return req & (~req + LIB_SWITCH_MAX_PORTS'(1));
  endfunction

endpackage

// File: rtl/lib_switch_rr_arbiter.sv
// Round-robin arbiter for one crossbar output; the pointer advances past each winner.
module lib_switch_rr_arbiter #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [0:N-1]  req,
  input  logic          en,
  output logic [0:N-1]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/lib_switch_arb_xbar.sv
// NxM crossbar with per-output round-robin arbitration and one registered slot per output.
// Optional per-output delivery counters: define LIB_SWITCH_STATS_EN.
module lib_switch_arb_xbar
  import lib_switch_pkg::*;
#(
  parameter int N     = LIB_SWITCH_N,
  parameter int M     = LIB_SWITCH_M,
  parameter int CNT_W = LIB_SWITCH_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  packet_t [0:N-1]     i_data,
  input  logic [0:N-1]        i_valid,
  input  logic [0:N-1][0:M-1] i_req,
  output logic [0:N-1]        o_ack,
  output packet_t [0:M-1]     o_data,
  output logic [0:M-1]        o_valid,
  input  logic [0:M-1]        i_ready
`ifdef LIB_SWITCH_STATS_EN
  ,
  output logic [0:M-1][CNT_W-1:0] o_count
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || M < 1 || M > LIB_SWITCH_MAX_PORTS || CNT_W < 1) begin : g_param_check
    $error("lib_switch_arb_xbar: unsupported N/M/CNT_W");
  end

  logic [0:M-1][0:N-1] req_t;
  logic [0:M-1][0:N-1] gnt;
  logic [0:M-1]        free;
  logic [IW-1:0]       gnt_idx [M];

  // Per input: resolve the destination, transpose into per-output request vectors, merge grants into ack.
  for (genvar j = 0; j < N; j++) begin : g_in
    logic [M-1:0] raw;
    logic [M-1:0] sel;
    logic [0:M-1] gcol;

    always_comb begin
      raw = '0;
      for (int i = 0; i < M; i++) raw[i] = i_valid[j] && i_req[j][i];
    end

    assign sel = M'(lowest_onehot(LIB_SWITCH_MAX_PORTS'(raw)));

    for (genvar i = 0; i < M; i++) begin : g_col
      assign req_t[i][j] = sel[i];
      assign gcol[i]     = gnt[i][j];
    end

    assign o_ack[j] = reset_n && (|gcol);
  end

  for (genvar i = 0; i < M; i++) begin : g_out
    assign free[i] = !o_valid[i] || i_ready[i];

    lib_switch_rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_t[i]),
      .en      (free[i]),
      .gnt     (gnt[i]),
      .gnt_idx (gnt_idx[i])
    );
  end

  // Output slot: refill on grant, drain when consumed with nothing new, hold while stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_valid <= '0;
      o_data  <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (free[i]) begin
          if (|gnt[i]) begin
            o_data[i]  <= i_data[gnt_idx[i]];
            o_valid[i] <= 1'b1;
          end else begin
            o_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef LIB_SWITCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_count <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (o_valid[i] && i_ready[i]) o_count[i] <= o_count[i] + CNT_W'(1);
      end
    end
  end
`endif

endmodule
